// File: rtl/m16_uart_pkg.sv
// Shared types and default constants for the M16 UART reply collectors.
package m16_uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF  = 17;
  localparam int unsigned PKT_BYTES_DEF     = 20;
  localparam int unsigned DIR_CYCLES_DEF    = 64;
  localparam int unsigned FIRST_TIMEOUT_DEF = 8192;
  localparam int unsigned GAP_TIMEOUT_DEF   = 340;
  localparam int unsigned ADDR_W_DEF        = 5;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_TMO_FIRST = 2'b01;
  localparam logic [1:0] ERR_TMO_GAP   = 2'b10;
  localparam logic [1:0] ERR_FRAME     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DIR,
    WAIT_FIRST,
    RX_BYTE,
    WAIT_GAP,
    DONE
  } pkt_state_t;

  typedef enum logic [1:0] {
    RXS_IDLE,
    RXS_HALF,
    RXS_DATA,
    RXS_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: line synchroniser, start-bit validation, mid-bit sampling.
module uart_rx_byte
  import m16_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk80MHz,
  input  logic       rst,
  input  logic       UART_RX,
  input  logic       arm,
  output logic       start_c,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       false_start,
  output logic [7:0] data
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       data_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic             byte_valid_d, frame_err_d, false_start_d;

  // Idle line is high, so the synchroniser resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bit_idx_d     = bit_idx;
    data_d        = data;
    byte_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    false_start_d = 1'b0;
    start_c       = arm && (state == RXS_IDLE) && rx_prev && !rx_sync;

    unique case (state)
      RXS_IDLE: begin
        if (start_c) begin
          state_d = RXS_HALF;
          cnt_d   = '0;
        end
      end
      RXS_HALF: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (rx_sync) begin
            false_start_d = 1'b1;
            state_d       = RXS_IDLE;
          end else begin
            state_d = RXS_DATA;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RXS_DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          data_d    = {rx_sync, data[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RXS_STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RXS_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d        = '0;
          byte_valid_d = rx_sync;
          frame_err_d  = !rx_sync;
          state_d      = RXS_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = RXS_IDLE;
    endcase

    // Losing arm aborts any byte in flight without reporting it.
    if (!arm) begin
      state_d       = RXS_IDLE;
      byte_valid_d  = 1'b0;
      frame_err_d   = 1'b0;
      false_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      state       <= RXS_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      data        <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      data        <= data_d;
      byte_valid  <= byte_valid_d;
      frame_err   <= frame_err_d;
      false_start <= false_start_d;
    end
  end

endmodule

// File: rtl/uart_pkt_collector.sv
// Per-channel RS485 reply collector: direction window, timeouts and byte
// indexing around uart_rx_byte, writing each byte into the frame buffer.
module uart_pkt_collector
  import m16_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int unsigned PKT_BYTES     = PKT_BYTES_DEF,
  parameter int unsigned DIR_CYCLES    = DIR_CYCLES_DEF,
  parameter int unsigned FIRST_TIMEOUT = FIRST_TIMEOUT_DEF,
  parameter int unsigned GAP_TIMEOUT   = GAP_TIMEOUT_DEF,
  parameter int unsigned ADDR_W        = ADDR_W_DEF
) (
  input  logic              clk80MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              UART_RX,
  output logic              UART_dRX,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              pkt_done,
  output logic              ValRX,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned DIR_W   = $clog2(DIR_CYCLES + 1);
  localparam int unsigned TMO_MAX = (FIRST_TIMEOUT > GAP_TIMEOUT) ? FIRST_TIMEOUT : GAP_TIMEOUT;
  localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);

  pkt_state_t        state, state_d;
  logic [DIR_W-1:0]  dir_cnt, dir_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic              drx_d, wr_en_d, pkt_done_d, val_d, busy_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic [1:0]        err_d;

  logic              arm;
  logic              rx_start_c, rx_byte_valid, rx_frame_err, rx_false_start;
  logic [7:0]        rx_data;

  assign arm = (state == WAIT_FIRST) || (state == WAIT_GAP) || (state == RX_BYTE);

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk80MHz    (clk80MHz),
    .rst         (rst),
    .UART_RX     (UART_RX),
    .arm         (arm),
    .start_c     (rx_start_c),
    .byte_valid  (rx_byte_valid),
    .frame_err   (rx_frame_err),
    .false_start (rx_false_start),
    .data        (rx_data)
  );

  always_comb begin
    state_d    = state;
    dir_cnt_d  = dir_cnt;
    tmo_cnt_d  = tmo_cnt;
    idx_d      = idx;
    drx_d      = UART_dRX;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    pkt_done_d = 1'b0;
    val_d      = ValRX;
    err_d      = err_code;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = DIR;
          dir_cnt_d = DIR_W'(DIR_CYCLES - 1);
          drx_d     = 1'b1;
          val_d     = 1'b0;
          err_d     = ERR_NONE;
          idx_d     = '0;
        end
      end
      DIR: begin
        if (dir_cnt == '0) begin
          drx_d     = 1'b0;
          state_d   = WAIT_FIRST;
          tmo_cnt_d = TMO_W'(FIRST_TIMEOUT);
        end else begin
          dir_cnt_d = dir_cnt - DIR_W'(1);
        end
      end
      WAIT_FIRST, WAIT_GAP: begin
        if (rx_start_c) begin
          state_d = RX_BYTE;
        end else if (tmo_cnt == '0) begin
          state_d    = DONE;
          pkt_done_d = 1'b1;
          err_d      = (state == WAIT_FIRST) ? ERR_TMO_FIRST : ERR_TMO_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt - TMO_W'(1);
        end
      end
      // Timeout is frozen while a byte is in flight; a false start resumes it.
      RX_BYTE: begin
        if (rx_byte_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx;
          wr_data_d = rx_data;
          if (idx == ADDR_W'(PKT_BYTES - 1)) begin
            state_d    = DONE;
            pkt_done_d = 1'b1;
            err_d      = ERR_NONE;
            val_d      = 1'b1;
          end else begin
            idx_d     = idx + ADDR_W'(1);
            state_d   = WAIT_GAP;
            tmo_cnt_d = TMO_W'(GAP_TIMEOUT);
          end
        end else if (rx_frame_err) begin
          state_d    = DONE;
          pkt_done_d = 1'b1;
          err_d      = ERR_FRAME;
        end else if (rx_false_start) begin
          state_d = (idx == '0) ? WAIT_FIRST : WAIT_GAP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dir_cnt  <= '0;
      tmo_cnt  <= '0;
      idx      <= '0;
      UART_dRX <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      pkt_done <= 1'b0;
      ValRX    <= 1'b0;
      err_code <= ERR_NONE;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      dir_cnt  <= dir_cnt_d;
      tmo_cnt  <= tmo_cnt_d;
      idx      <= idx_d;
      UART_dRX <= drx_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      pkt_done <= pkt_done_d;
      ValRX    <= val_d;
      err_code <= err_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_pkt_collector.sv
// Scoreboard bench for uart_pkt_collector: directed packets, timeouts, framing, reset.
module tb_uart_pkt_collector;
  import m16_uart_pkg::*;

  localparam int unsigned CPB  = 17;
  localparam int unsigned NB   = 20;
  localparam int unsigned DIRC = 64;
  localparam int unsigned FTO  = 8192;
  localparam int unsigned GTO  = 340;
  localparam int unsigned AW   = 5;

  logic          clk80MHz = 1'b0;
  logic          rst      = 1'b0;
  logic          start    = 1'b0;
  logic          UART_RX  = 1'b1;
  logic          UART_dRX;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          pkt_done;
  logic          ValRX;
  logic [1:0]    err_code;
  logic          busy;

  uart_pkt_collector dut (
    .clk80MHz (clk80MHz),
    .rst      (rst),
    .start    (start),
    .UART_RX  (UART_RX),
    .UART_dRX (UART_dRX),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pkt_done (pkt_done),
    .ValRX    (ValRX),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk80MHz = ~clk80MHz;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_exp_t;

  typedef struct packed {
    logic [1:0] err;
    logic       val;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  int done_seen = 0, done_exp_cnt = 0, wr_seen = 0;
  int drx_high_cnt = 0, drx_fall_cyc = 0, done_cyc = 0, wr_cyc = 0;
  logic prev_drx = 1'b0;

  // Monitor: samples on the falling edge and pops the scoreboard on each strobe.
  initial begin
    wr_exp_t   we;
    done_exp_t de;
    forever begin
      @(negedge clk80MHz);
      cyc++;
      if (UART_dRX) drx_high_cnt++;
      if (prev_drx && !UART_dRX) drx_fall_cyc = cyc;
      prev_drx = UART_dRX;
      if (wr_en) begin
        wr_seen++;
        wr_cyc = cyc;
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got addr=%0d data=0x%02h, want no write", wr_addr, wr_data);
        end else begin
          we = wr_q.pop_front();
          if (wr_addr !== we.addr || wr_data !== we.data) begin
            fails++;
            $display("FAIL wr: got addr=%0d data=0x%02h, want addr=%0d data=0x%02h",
                     wr_addr, wr_data, we.addr, we.data);
          end
        end
      end
      if (pkt_done) begin
        done_seen++;
        done_cyc = cyc;
        tests++;
        if (done_q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: got err=%0d val=%0d, want no pkt_done", err_code, ValRX);
        end else begin
          de = done_q.pop_front();
          if (err_code !== de.err || ValRX !== de.val) begin
            fails++;
            $display("FAIL done: got err=%0d val=%0d, want err=%0d val=%0d",
                     err_code, ValRX, de.err, de.val);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk80MHz);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk80MHz); #1 start = 1'b1;
    @(posedge clk80MHz); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] v;
    v = b;
    UART_RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = v[i];
      tick(CPB);
    end
    UART_RX = stop_bit;
    tick(CPB);
    UART_RX = 1'b1;
    tick(CPB);
  endtask

  task automatic expect_wr(input int addr, input int data);
    wr_exp_t e;
    e.addr = AW'(addr);
    e.data = 8'(data);
    wr_q.push_back(e);
  endtask

  task automatic expect_done(input logic [1:0] err, input logic val);
    done_exp_t e;
    e.err = err;
    e.val = val;
    done_q.push_back(e);
    done_exp_cnt++;
  endtask

  task automatic start_and_wait_dir(input string name);
    int old, n;
    old = drx_fall_cyc;
    drx_high_cnt = 0;
    pulse_start();
    n = 0;
    while (drx_fall_cyc == old && n < 200) begin
      tick(1);
      n++;
    end
    if (drx_fall_cyc == old) begin
      tests++;
      fails++;
      $display("FAIL %s: UART_dRX did not fall within 200 cycles", name);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_seen < done_exp_cnt && n < budget) begin
      tick(1);
      n++;
    end
    if (done_seen < done_exp_cnt) begin
      tests++;
      fails++;
      $display("FAIL %s: pkt_done not seen within %0d cycles", name, budget);
      done_exp_cnt = done_seen;
      done_q.delete();
      wr_q.delete();
    end
    tick(3);
  endtask

  task automatic send_packet(input int mult, input int ofs);
    for (int i = 0; i < int'(NB); i++) send_byte(8'((i * mult + ofs) & 255), 1'b1);
  endtask

  initial begin
    int w0, gap;

    // Reset state
    tick(5);
    check("reset_outs", int'({UART_dRX, wr_en, wr_addr, wr_data, pkt_done, ValRX, err_code, busy}), 0);
    #1 rst = 1'b1;
    tick(5);
    check("idle_busy", int'(busy), 0);

    // 1: full good packet 0,10,..,190
    for (int i = 0; i < int'(NB); i++) expect_wr(i, i * 10);
    expect_done(ERR_NONE, 1'b1);
    start_and_wait_dir("t1_dir");
    check("t1_dir_len", drx_high_cnt, int'(DIRC));
    tick(30 * CPB);
    check("t1_busy", int'(busy), 1);
    send_packet(10, 0);
    wait_done("t1_done", 2000);
    check("t1_valrx", int'(ValRX), 1);
    check("t1_err", int'(err_code), int'(ERR_NONE));
    check("t1_busy_after", int'(busy), 0);
    check("t1_wr_left", wr_q.size(), 0);

    // 2: no reply at all
    w0 = wr_seen;
    expect_done(ERR_TMO_FIRST, 1'b0);
    start_and_wait_dir("t2_dir");
    check("t2_dir_len", drx_high_cnt, int'(DIRC));
    check("t2_valrx_cleared", int'(ValRX), 0);
    wait_done("t2_done", int'(FTO) + 500);
    check("t2_tmo_cycles", done_cyc - drx_fall_cyc, int'(FTO) + 1);
    check("t2_no_writes", wr_seen - w0, 0);
    check("t2_err_held", int'(err_code), int'(ERR_TMO_FIRST));

    // 3: seven bytes then silence
    for (int i = 0; i < 7; i++) expect_wr(i, 8'hA0 + i);
    expect_done(ERR_TMO_GAP, 1'b0);
    start_and_wait_dir("t3_dir");
    tick(5 * CPB);
    for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i), 1'b1);
    wait_done("t3_done", int'(GTO) + 500);
    gap = done_cyc - wr_cyc;
    check("t3_gap_window", int'(gap >= int'(GTO) && gap <= int'(GTO) + 3), 1);
    check("t3_wr_left", wr_q.size(), 0);

    // 4: framing error on byte 3
    for (int i = 0; i < 3; i++) expect_wr(i, 8'h55 ^ i);
    expect_done(ERR_FRAME, 1'b0);
    start_and_wait_dir("t4_dir");
    tick(5 * CPB);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h55 ^ i), 1'b1);
    send_byte(8'h3C, 1'b0);
    wait_done("t4_done", 2000);
    check("t4_valrx", int'(ValRX), 0);
    check("t4_err_held", int'(err_code), int'(ERR_FRAME));

    // 5: short glitch before the packet is rejected
    for (int i = 0; i < int'(NB); i++) expect_wr(i, (i * 7 + 3) & 255);
    expect_done(ERR_NONE, 1'b1);
    start_and_wait_dir("t5_dir");
    tick(4 * CPB);
    UART_RX = 1'b0;
    tick(4);
    UART_RX = 1'b1;
    tick(3 * CPB);
    send_packet(7, 3);
    wait_done("t5_done", 2000);
    check("t5_valrx", int'(ValRX), 1);

    // 6: reset mid-packet, then a clean packet with an ignored second start
    for (int i = 0; i < 10; i++) expect_wr(i, 8'hF0 - i);
    start_and_wait_dir("t6_dir");
    tick(5 * CPB);
    for (int i = 0; i < 10; i++) send_byte(8'(8'hF0 - i), 1'b1);
    UART_RX = 1'b0;
    tick(3 * CPB);
    rst = 1'b0;
    tick(3);
    check("t6_reset_outs", int'({UART_dRX, wr_en, wr_addr, wr_data, pkt_done, ValRX, err_code, busy}), 0);
    check("t6_wr_left", wr_q.size(), 0);
    UART_RX = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(5);
    check("t6_idle_after_reset", int'(busy), 0);
    for (int i = 0; i < int'(NB); i++) expect_wr(i, (i * 13 + 1) & 255);
    expect_done(ERR_NONE, 1'b1);
    start_and_wait_dir("t6b_dir");
    tick(5 * CPB);
    fork
      send_packet(13, 1);
      begin
        tick(8 * 10 * CPB);
        pulse_start();
      end
    join
    wait_done("t6_done", 2000);
    check("t6_valrx", int'(ValRX), 1);
    check("t6_err", int'(err_code), int'(ERR_NONE));
    check("t6_wr_left_final", wr_q.size(), 0);
    check("t6_done_left", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_pkt_collector.md
Name: uart_pkt_collector

Overview:
Per-channel RS485 reply collector that sits directly upstream of the M16 orbital frame assembler. Once per frame cycle it opens a reply window and drives the transceiver direction line. It then deserialises a fixed-length UART reply packet (8N1, LSB first) and writes each byte into the assembler's channel buffer. It reports completion, timeout or framing error, and one instance serves each of UART channels 1..5.

Parameters:
CLKS_PER_BIT, 17, clk80MHz cycles per UART bit (4.8 Mbaud at 80 MHz is 16.67; accepted rounding)
PKT_BYTES, 20, bytes per reply packet
DIR_CYCLES, 64, cycles UART_dRX is held high after start
FIRST_TIMEOUT, 8192, max cycles from dRX fall to the first start bit
GAP_TIMEOUT, 340, max cycles from one stop-bit sample to the next start bit
ADDR_W, 5, buffer address width; must satisfy 2^ADDR_W >= PKT_BYTES

Ports:
clk80MHz  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request pulse from the frame sequencer
UART_RX  in  1  serial input, asynchronous to clk80MHz
UART_dRX  out  1  RS485 direction control, high during request window
wr_en  out  1  one-cycle buffer write strobe
wr_addr  out  ADDR_W  byte index 0..PKT_BYTES-1
wr_data  out  8  received byte
pkt_done  out  1  one-cycle pulse on packet end (good or bad)
ValRX  out  1  level: last packet complete and error-free
err_code  out  2  00 none, 01 first-byte timeout, 10 gap timeout, 11 framing error
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; UART_RX synchroniser flops reset to 1.
- UART_RX passes through a 2-FF synchroniser. A start edge is a 1->0 transition on the synchronised signal.
- IDLE: on start, go to DIR. Clear ValRX and err_code. Load the direction counter.
- DIR: UART_dRX = 1 for exactly DIR_CYCLES cycles, then drop it and go to WAIT_FIRST. The timeout counter is loaded with FIRST_TIMEOUT. Line activity during DIR is ignored.
- WAIT_FIRST / WAIT_GAP:
  - On a start edge, go to RX_BYTE.
  - If the counter expires first, go to DONE with err 01 (WAIT_FIRST) or 10 (WAIT_GAP).
- RX_BYTE, handled by the sub-module:
  - Wait CLKS_PER_BIT/2 (8) cycles, then re-check the line. If it is high, treat it as a false start and return to the wait state with its counter still running.
  - Sample 8 data bits at CLKS_PER_BIT intervals, LSB first, then sample the stop bit.
- Stop bit = 1: on the cycle after the stop sample, assert wr_en for one cycle with wr_data = byte and wr_addr = byte index.
  - Index below PKT_BYTES-1: increment the index, go to WAIT_GAP and load GAP_TIMEOUT.
  - Last byte: go to DONE with err 00.
- Stop bit = 0: no write. Go to DONE with err 11.
- DONE (one cycle):
  - pulse pkt_done;
  - err_code is latched and held until the next start;
  - ValRX = 1 only if err 00, held until the next start;
  - return to IDLE.
- start while busy=1 is ignored, with no restart.
- wr_addr wraps only via restart. The index resets to 0 on every start and never exceeds PKT_BYTES-1.
- A partial packet leaves bytes already written in the buffer. The consumer qualifies them with ValRX.
- Reset asserted mid-packet: immediate return to IDLE, outputs cleared, no wr_en or pkt_done.
- start and a start edge in the same cycle: start wins and the line edge is ignored.

Decomposition:
- Shared package m16_uart_pkg holds:
  - the state enum (IDLE, DIR, WAIT_FIRST, RX_BYTE, WAIT_GAP, DONE);
  - the err_code constants ERR_NONE, ERR_TMO_FIRST, ERR_TMO_GAP, ERR_FRAME;
  - default baud and packet constants.
- Sub-module uart_rx_byte: synchroniser, start validation, bit timing and shift register.
  - Interface: arm in; byte_valid, frame_err, false_start out; data[7:0] out.
- The top level owns the packet FSM, direction timing, timeouts and byte index.

Test Plan:
1. start pulse, then after dRX falls wait 30 bit times and send 20 bytes {0x00,10,20,...,190}, 1 idle bit apart -> UART_dRX high exactly 64 cycles; 20 wr_en strobes with addr 0..19 and data matching; pkt_done with err 00; ValRX=1.
2. start, no line activity -> pkt_done exactly FIRST_TIMEOUT+1 cycles after dRX falls; err 01; ValRX=0; no wr_en.
3. Send 7 good bytes, then go silent -> 7 writes (addr 0..6); err 10 at GAP_TIMEOUT after the 7th stop sample.
4. Byte 3 sent with stop bit 0 -> writes for addr 0..2 only; err 11; ValRX=0.
5. 4-cycle low glitch before the first byte, then a normal packet -> glitch rejected; packet received with err 00.
6. Assert rst at byte 10 of a packet, release, then start and send a full packet -> outputs 0 during reset; new packet written from addr 0; ValRX=1. A second start pulse sent mid-packet has no effect.
